video_gen: RTL and testbench
============================

VIDEO_GEN -- requirements
Module: video_gen

Interface
REQ-001 The module SHALL have these parameters:
- HTOTAL, 448, ce-ticks per line.
- VTOTAL, 312, lines per frame.
- HACTIVE, 256, active pixels per line; power of two, at least 8.
- VACTIVE, 248, active lines; at most 2^VBITS.
- HBLANK_START, 320, first blanked hCount.
- HBLANK_END, 415, last blanked hCount.
- HSYNC_START / HSYNC_END, 344 / 375, inclusive hsync range.
- VSYNC_START / VSYNC_END, 272 / 275, inclusive vsync range.
- INT_LEN, 64, interrupt timeout in ce-ticks.
- CW, 3, bits per colour channel.
REQ-002 The module SHALL have these localparams:
- HBITS = clog2(HACTIVE).
- VBITS = clog2(VACTIVE).
- AW = VBITS + HBITS - 3.
REQ-003 The module SHALL have these ports:
- clock, in, 1: single clock.
- reset, in, 1: synchronous, active-low reset.
- ce, in, 1: pixel clock enable.
- altg, in, 1: 1 selects the greenx plane instead of the green plane.
- border, in, 3: {r,g,b} colour for the non-active, non-blanked area.
- intAck, in, 1: interrupt acknowledge, sampled on ce.
- int, out, 1: active-low frame interrupt.
- stdn, out, 2: constant 2'b01 (PAL).
- sync, out, 2: {1'b1, composite sync active-low}.
- rgb, out, 3*CW: {R,G,B}.
- d, in, 8: video RAM data.
- b, out, 2: plane select.
- a, out, AW: video RAM address.

Function
REQ-004 All state SHALL advance only on clock edges with ce=1; when ce=0 all state SHALL hold.
REQ-005 hCount SHALL count 0..HTOTAL-1 and wrap to 0.
REQ-006 vCount SHALL increment when hCount wraps, counting 0..VTOTAL-1 and wrapping to 0.
REQ-007 dataEnable SHALL be defined as hCount<HACTIVE and vCount<VACTIVE.
REQ-008 videoEnable SHALL load dataEnable on every ce-tick where hCount[2]=1.
REQ-009 Plane fetch:
- b SHALL equal hCount[2:1].
- a SHALL equal {vCount[VBITS-1:0], hCount[HBITS-1:3]}.
REQ-010 Plane latches SHALL load d when dataEnable is 1, at these hCount[2:0] slots:
- 1 loads blue.
- 3 loads red.
- 5 loads greenx.
REQ-011 At hCount[2:0]=7 with videoEnable=1:
- the four shifters SHALL load blue, red, greenx and green (green taken from d directly);
- otherwise they SHALL shift left by one, filling with 0.
REQ-012 Pixel output is the MSB of each shifter, so the first pixel appears on the tick after the load, MSB-first.
REQ-013 blank SHALL be defined as (HBLANK_START<=hCount<=HBLANK_END) or (VACTIVE<=vCount<VACTIVE+8).
REQ-014 rgb SHALL be selected in this priority order:
- blank gives 0.
- videoEnable=0 gives border, with each bit replicated CW times.
- otherwise each channel SHALL be its shifter MSB replicated CW times; green uses greenx when altg=1.
REQ-015 sync[0] SHALL be the inverse of (hsync OR vsync), where each is its inclusive parameter range on hCount or vCount respectively.
REQ-016 Interrupt state machine, with states IDLE and PEND:
- IDLE goes to PEND on a ce-tick with vCount=VACTIVE and hCount=2; the timer clears.
- In PEND the timer increments each ce-tick.
- PEND goes to IDLE when intAck=1 or when the timer reaches INT_LEN-1.
- int SHALL be 0 exactly while in PEND.
REQ-017 When the entry condition and intAck coincide, entry SHALL win and the state SHALL remain PEND.
REQ-018 intAck SHALL be ignored in IDLE.

Reset
REQ-019 On reset=0 at a clock edge, regardless of ce, the following SHALL be cleared:
- hCount, vCount.
- All latches and shifters.
- videoEnable.
- Interrupt timer, with state set to IDLE.
REQ-020 While reset=0, the outputs SHALL be:
- int=1.
- sync=2'b11.
- rgb = border replicated.
- a=0, b=0.
REQ-021 When reset is asserted mid-frame, counting SHALL restart from (0,0) on the first ce-tick after reset=1, and any pending interrupt SHALL be dropped.

Configuration
REQ-022 If SCANLINE_EN is defined, active pixels on odd vCount SHALL output each lit channel as {1'b0, (CW-1) ones}.
REQ-023 If SCANLINE_EN is undefined, all lines SHALL output full intensity, and no scanline logic SHALL be synthesised.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset held with ce=1, border=3'b101 -> int=1, sync=11, rgb=9'b111000111, a=0; after release hCount advances one per ce.
- Free run with defaults -> line=448 ticks, frame=312 lines; sync[0]=0 for hCount 344..375 and for all of lines 272..275.
- d=0x80 at slots 1/3/5, d=0x01 at slot 7, altg=0 -> rgb=9'b111000111 at the first pixel, rgb=0 for pixels 2-7 and 9'b000111000 at the 8th; with altg=1 the green channel follows greenx.
- Line 248, hCount=2 -> int falls; intAck pulsed at tick 10 -> int=1 at tick 11.
- No intAck -> int low for exactly 64 ce-ticks.
- SCANLINE_EN defined, all planes 0xFF -> line 0 rgb=9'h1FF, line 1 rgb=9'b011011011.

Source files
------------

// File: rtl/video_gen_if.sv
// Video RAM fetch bus between the video generator and its plane memory.
// The generator is the master: it drives the address and plane select,
// and the memory returns one byte of plane data.
interface video_gen_if #(
    parameter int AW = 13
);
    logic [7:0]    d;
    logic [1:0]    b;
    logic [AW-1:0] a;

    modport master (input d, output b, output a);
    modport slave  (output d, input b, input a);
endinterface

// File: rtl/video_gen.sv
// video_gen: PAL-style raster generator with a four-plane bitmap fetch
// (blue, red, greenx, green), border/blank colouring, composite sync and a
// timed, acknowledgeable frame interrupt.
// Optional feature macro: SCANLINE_EN -- when defined, active pixels on odd
// lines are dimmed to {0, 1..1} per lit channel.
module video_gen #(
    parameter int HTOTAL       = 448,
    parameter int VTOTAL       = 312,
    parameter int HACTIVE      = 256,
    parameter int VACTIVE      = 248,
    parameter int HBLANK_START = 320,
    parameter int HBLANK_END   = 415,
    parameter int HSYNC_START  = 344,
    parameter int HSYNC_END    = 375,
    parameter int VSYNC_START  = 272,
    parameter int VSYNC_END    = 275,
    parameter int INT_LEN      = 64,
    parameter int CW           = 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ce,
    input  logic            altg,
    input  logic [2:0]      border,
    input  logic            intAck,
    output logic            int_n,
    output logic [1:0]      stdn,
    output logic [1:0]      sync,
    output logic [3*CW-1:0] rgb,
    video_gen_if.master     ram
);
    localparam int HBITS = $clog2(HACTIVE);
    localparam int VBITS = $clog2(VACTIVE);
    localparam int AW    = VBITS + HBITS - 3;
    localparam int HW    = $clog2(HTOTAL);
    localparam int VW    = $clog2(VTOTAL);
    localparam int TW    = $clog2(INT_LEN);

    localparam logic [HW-1:0] H_LAST  = HW'(HTOTAL - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(VTOTAL - 1);
    localparam logic [HW-1:0] H_ACT   = HW'(HACTIVE);
    localparam logic [VW-1:0] V_ACT   = VW'(VACTIVE);
    localparam logic [VW-1:0] V_BLK_E = VW'(VACTIVE + 8);
    localparam logic [HW-1:0] HB_S    = HW'(HBLANK_START);
    localparam logic [HW-1:0] HB_E    = HW'(HBLANK_END);
    localparam logic [HW-1:0] HS_S    = HW'(HSYNC_START);
    localparam logic [HW-1:0] HS_E    = HW'(HSYNC_END);
    localparam logic [VW-1:0] VS_S    = VW'(VSYNC_START);
    localparam logic [VW-1:0] VS_E    = VW'(VSYNC_END);
    localparam logic [HW-1:0] H_INT   = HW'(2);
    localparam logic [TW-1:0] T_LAST  = TW'(INT_LEN - 1);

    typedef enum logic {IDLE, PEND} int_state_t;

    logic [HW-1:0] h_count;
    logic [VW-1:0] v_count;
    logic          data_enable;
    logic          video_enable;
    logic [7:0]    blue, red, greenx;
    logic [7:0]    blue_sr, red_sr, greenx_sr, green_sr;
    logic          blank, hsync, vsync, int_entry, g_bit;
    logic [AW-1:0] addr;
    int_state_t    state, state_next;
    logic [TW-1:0] timer, timer_next;

    function automatic logic [CW-1:0] expand(input logic on);
        return {CW{on}};
    endfunction

`ifdef SCANLINE_EN
    function automatic logic [CW-1:0] dim(input logic on);
        return on ? {1'b0, {(CW-1){1'b1}}} : '0;
    endfunction
`endif

    assign data_enable = (h_count < H_ACT) && (v_count < V_ACT);
    assign blank       = ((h_count >= HB_S) && (h_count <= HB_E)) ||
                         ((v_count >= V_ACT) && (v_count < V_BLK_E));
    assign hsync       = (h_count >= HS_S) && (h_count <= HS_E);
    assign vsync       = (v_count >= VS_S) && (v_count <= VS_E);
    assign int_entry   = (v_count == V_ACT) && (h_count == H_INT);
    assign g_bit       = altg ? greenx_sr[7] : green_sr[7];
    assign addr        = {v_count[VBITS-1:0], h_count[HBITS-1:3]};

    assign stdn  = 2'b01;
    assign sync  = reset ? {1'b1, ~(hsync | vsync)} : 2'b11;
    assign int_n = reset ? (state != PEND) : 1'b1;
    assign ram.a = reset ? addr : '0;
    assign ram.b = reset ? h_count[2:1] : '0;

    // Raster position: pixel counter wraps each line, line counter each frame.
    always_ff @(posedge clock) begin
        if (!reset) begin
            h_count <= '0;
            v_count <= '0;
        end else if (ce) begin
            if (h_count == H_LAST) begin
                h_count <= '0;
                v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
            end else begin
                h_count <= h_count + 1'b1;
            end
        end
    end

    // Plane fetch: latch three planes mid-group, then load all four shifters
    // at the last slot so the byte plays out over the following 8 ticks.
    always_ff @(posedge clock) begin
        if (!reset) begin
            video_enable <= 1'b0;
            blue         <= '0;
            red          <= '0;
            greenx       <= '0;
            blue_sr      <= '0;
            red_sr       <= '0;
            greenx_sr    <= '0;
            green_sr     <= '0;
        end else if (ce) begin
            if (h_count[2]) video_enable <= data_enable;
            if (data_enable) begin
                case (h_count[2:0])
                    3'd1:    blue   <= ram.d;
                    3'd3:    red    <= ram.d;
                    3'd5:    greenx <= ram.d;
                    default: ;
                endcase
            end
            if ((h_count[2:0] == 3'd7) && video_enable) begin
                blue_sr   <= blue;
                red_sr    <= red;
                greenx_sr <= greenx;
                green_sr  <= ram.d;
            end else begin
                blue_sr   <= {blue_sr[6:0], 1'b0};
                red_sr    <= {red_sr[6:0], 1'b0};
                greenx_sr <= {greenx_sr[6:0], 1'b0};
                green_sr  <= {green_sr[6:0], 1'b0};
            end
        end
    end

    // Colour output: blanking beats border, border beats bitmap pixels.
    always_comb begin
        rgb = {expand(border[2]), expand(border[1]), expand(border[0])};
        if (reset) begin
            if (blank) begin
                rgb = '0;
            end else if (video_enable) begin
                rgb = {expand(red_sr[7]), expand(g_bit), expand(blue_sr[7])};
`ifdef SCANLINE_EN
                if (v_count[0]) rgb = {dim(red_sr[7]), dim(g_bit), dim(blue_sr[7])};
`endif
            end
        end
    end

    // Interrupt state and timeout timer registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            timer <= '0;
        end else if (ce) begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    // Interrupt next state: frame entry has priority over acknowledge/timeout.
    always_comb begin
        state_next = state;
        timer_next = timer;
        if (int_entry) begin
            state_next = PEND;
            timer_next = '0;
        end else if (state == PEND) begin
            if (intAck || (timer == T_LAST)) state_next = IDLE;
            else                             timer_next = timer + 1'b1;
        end
    end
endmodule

// File: tb/tb_video_gen.sv
// Self-checking bench for video_gen: a default-size instance for line-level
// timing and pixel output, and a small-raster instance for frame, vsync and
// interrupt behaviour within a short run.
module tb_video_gen;
    logic       clock, reset, ce, altg, intAck;
    logic [2:0] border;
    logic       int_n, int_s;
    logic [1:0] stdn, stdn_s, sync, sync_s;
    logic [8:0] rgb, rgb_s;

    video_gen_if #(.AW(13)) vid ();
    video_gen_if #(.AW(7))  vid_s ();

    video_gen dut (
        .clock(clock), .reset(reset), .ce(ce), .altg(altg), .border(border),
        .intAck(intAck), .int_n(int_n), .stdn(stdn), .sync(sync), .rgb(rgb),
        .ram(vid)
    );

    video_gen #(
        .HTOTAL(80), .VTOTAL(40), .HACTIVE(32), .VACTIVE(24),
        .HBLANK_START(48), .HBLANK_END(63), .HSYNC_START(52), .HSYNC_END(59),
        .VSYNC_START(28), .VSYNC_END(30), .INT_LEN(64), .CW(3)
    ) dut_s (
        .clock(clock), .reset(reset), .ce(ce), .altg(altg), .border(border),
        .intAck(intAck), .int_n(int_s), .stdn(stdn_s), .sync(sync_s), .rgb(rgb_s),
        .ram(vid_s)
    );

    typedef struct {
        logic [7:0] d;
        logic       altg;
        logic [8:0] rgb;
    } vec_t;

    vec_t       tbl [32];
    int         n;
    int         n_cmp;
    int         n_bad;
    int         h;
    logic [8:0] exp_sl;

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time expired, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic step();
        ce = 1'b1;
        tick();
        n++;
    endtask

    task automatic go(input int target);
        while (n < target) step();
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        ce    = 1'b1;
        tick();
        reset = 1'b1;
        n     = 0;
    endtask

    function automatic int pd(input int v, input int hh);
        return v * 448 + hh;
    endfunction

    function automatic int ps(input int f, input int v, input int hh);
        return (f * 40 + v) * 80 + hh;
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;
        n     = 0;
        // pixel pipeline vectors: planes 0x80 at slots 1/3/5, green 0x01 at slot 7
        for (int i = 0; i < 32; i++) begin
            h = i % 16;
            tbl[i].altg = (i >= 16);
            tbl[i].d    = (h == 1 || h == 3 || h == 5) ? 8'h80 : ((h == 7) ? 8'h01 : 8'h00);
            tbl[i].rgb  = (h <= 4) ? 9'b000000111 : 9'b000000000;
        end
        tbl[8].rgb  = 9'b111000111;
        tbl[15].rgb = 9'b000111000;
        tbl[24].rgb = 9'b111111111;
        tbl[31].rgb = 9'b000000000;

        clock  = 1'b0;
        reset  = 1'b0;
        ce     = 1'b1;
        altg   = 1'b0;
        intAck = 1'b0;
        border = 3'b101;
        vid.d  = 8'h00;
        vid_s.d = 8'h00;

        // reset held with ce=1
        repeat (3) tick();
        chk("rst_int", int_n, 1'b1);
        chk("rst_sync", sync, 2'b11);
        chk("rst_rgb", rgb, 9'b111000111);
        chk("rst_a", vid.a, 13'd0);
        chk("rst_b", vid.b, 2'd0);
        chk("rst_stdn", stdn, 2'b01);
        chk("rst_int_s", int_s, 1'b1);
        ce = 1'b0;
        tick();
        chk("rst_rgb_ce0", rgb, 9'b111000111);

        // release: one hCount step per ce
        reset = 1'b1;
        n = 0;
        step();
        chk("adv_h1_b", vid.b, 2'd0);
        step();
        chk("adv_h2_b", vid.b, 2'd1);
        ce = 1'b0;
        tick();
        chk("hold_ce0_b", vid.b, 2'd1);
        step();
        chk("adv_h3_b", vid.b, 2'd1);
        step();
        chk("adv_h4_b", vid.b, 2'd2);
        go(8);
        chk("adv_h8_a", vid.a, 13'd1);

        // table-driven pixel pipeline, altg=0 then altg=1
        border = 3'b001;
        for (int i = 0; i < 32; i++) begin
            if (i % 16 == 0) reset_pulse();
            vid.d = tbl[i].d;
            altg  = tbl[i].altg;
            chk($sformatf("pix%0d", i), rgb, tbl[i].rgb);
            step();
        end

        // full-line run with all planes 0xFF
        altg   = 1'b0;
        border = 3'b110;
        reset_pulse();
        vid.d = 8'hFF;
        go(pd(0, 8));   chk("line0_px0", rgb, 9'h1FF);
        go(pd(0, 319)); chk("pre_blank", rgb, 9'b111111000);
        go(pd(0, 320)); chk("blank_start", rgb, 9'd0);
        go(pd(0, 343)); chk("hs_343", sync, 2'b11);
        go(pd(0, 344)); chk("hs_344", sync, 2'b10);
        go(pd(0, 375)); chk("hs_375", sync, 2'b10);
        go(pd(0, 376)); chk("hs_376", sync, 2'b11);
        go(pd(0, 415)); chk("blank_end", rgb, 9'd0);
        go(pd(0, 416)); chk("post_blank", rgb, 9'b111111000);
        go(pd(0, 447)); chk("h447_a", vid.a, 13'd23);
        chk("h447_b", vid.b, 2'd3);
        go(pd(1, 0));   chk("wrap_a", vid.a, 13'd32);
        chk("wrap_b", vid.b, 2'd0);
`ifdef SCANLINE_EN
        exp_sl = 9'b011011011;
`else
        exp_sl = 9'h1FF;
`endif
        go(pd(1, 8));   chk("line1_px0", rgb, exp_sl);

        // small raster: sync, frame wrap, interrupt
        vid.d = 8'h00;
        reset_pulse();
        go(ps(0, 0, 51));  chk("s_hs51", sync_s, 2'b11);
        go(ps(0, 0, 52));  chk("s_hs52", sync_s, 2'b10);
        go(ps(0, 0, 59));  chk("s_hs59", sync_s, 2'b10);
        go(ps(0, 0, 60));  chk("s_hs60", sync_s, 2'b11);
        go(ps(0, 24, 2));  chk("irq_before", int_s, 1'b1);
        go(ps(0, 24, 3));  chk("irq_fall", int_s, 1'b0);
        go(ps(0, 24, 66)); chk("irq_t64", int_s, 1'b0);
        go(ps(0, 24, 67)); chk("irq_timeout", int_s, 1'b1);
        go(ps(0, 27, 0));  chk("s_vs27", sync_s, 2'b11);
        go(ps(0, 28, 0));  chk("s_vs28", sync_s, 2'b10);
        go(ps(0, 30, 79)); chk("s_vs30", sync_s, 2'b10);
        go(ps(0, 31, 0));  chk("s_vs31", sync_s, 2'b11);
        go(ps(0, 39, 79)); chk("s_last_a", vid_s.a, 7'd29);
        go(ps(1, 0, 0));   chk("s_frame_wrap_a", vid_s.a, 7'd0);

        // frame 1: ack ignored in IDLE, entry wins over coincident ack, ack at tick 10
        go(ps(1, 23, 70));
        intAck = 1'b1;
        go(ps(1, 24, 2));  chk("ack_idle", int_s, 1'b1);
        step();            chk("entry_wins", int_s, 1'b0);
        intAck = 1'b0;
        go(ps(1, 24, 11)); chk("irq_t9", int_s, 1'b0);
        go(ps(1, 24, 12)); chk("irq_t10", int_s, 1'b0);
        intAck = 1'b1;
        step();            chk("irq_ack_t11", int_s, 1'b1);
        intAck = 1'b0;
        go(ps(1, 24, 20)); chk("irq_stays_idle", int_s, 1'b1);

        // frame 2: reset during a pending interrupt
        go(ps(2, 24, 20)); chk("irq_pend_f2", int_s, 1'b0);
        reset = 1'b0;
        ce    = 1'b0;
        tick();
        chk("mid_rst_int", int_s, 1'b1);
        chk("mid_rst_sync", sync_s, 2'b11);
        chk("mid_rst_a", vid_s.a, 7'd0);
        reset = 1'b1;
        tick();
        n = 0;
        step();
        step();
        chk("restart_b", vid_s.b, 2'd1);
        chk("restart_a", vid_s.a, 7'd0);
        chk("restart_int", int_s, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
